inst_fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the CPU decode/ALU datapath and supplies its Inst_code.
- Holds the program counter and issues word reads to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned words in a 2-entry queue and presents them to decode with a valid/ready handshake.
- Accepts branch/jump redirects from the execute side.

---
 rtl/inst_fetch_unit.sv | 143 ++++++++++++++
 tb/tb_inst_fetch_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_unit
// Purpose  : Instruction fetch stage. Holds the PC and issues word reads to a
//            synchronous instruction memory with a 1-cycle read latency.
//            Returned words go into a 2-entry queue that is presented to
//            decode with a valid/ready handshake. Branch/jump redirects from
//            execute flush the queue and restart fetch at the target.
// Ports    : clk, rst                 - clock, async active-high reset
//            imem_en/addr/rdata       - instruction memory read port
//            redirect_valid/pc        - branch/jump redirect from execute
//            inst_valid/ready         - decode handshake
//            Inst_code, inst_pc,
//            inst_pc_plus4            - queue head (zero while empty)
//            misalign_err             - sticky misaligned-redirect flag
//            halted                   - fetch stopped by a halt opcode
// Options  : FETCH_HALT_EN - when defined, a fetched word with op_code
//            [31:26] = 6'b111111 halts further fetching until a redirect.
//            When undefined, halted is tied 0.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_unit #(
  parameter int                  PC_WIDTH = 32,
  parameter int                  IMEM_AW  = 6,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_en,
  output logic [IMEM_AW-1:0]  imem_addr,
  input  logic [31:0]         imem_rdata,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [31:0]         Inst_code,
  output logic [PC_WIDTH-1:0] inst_pc,
  output logic [PC_WIDTH-1:0] inst_pc_plus4,
  output logic                misalign_err,
  output logic                halted
);

  logic [PC_WIDTH-1:0] fetch_pc;
  logic [PC_WIDTH-1:0] tag_pc;
  logic                tag_epoch;
  logic                epoch;
  logic                inflight;
  logic [1:0]          count;
  logic [31:0]         q0_data, q1_data;
  logic [PC_WIDTH-1:0] q0_pc, q1_pc;

  logic                pop;
  logic                push;
  logic                issue;
  logic                halt_q;
  logic [2:0]          occupancy;
  logic [1:0]          count_after_pop;

  assign inst_valid = (count != 2'd0);
  assign pop        = inst_valid & inst_ready;

  // Slots already committed (queued + in flight) minus what decode takes now.
  assign occupancy       = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign count_after_pop = count - {1'b0, pop};

  // Held low during reset so the first issue lands the cycle after release.
  assign issue = ~rst & ~redirect_valid & ~halt_q & (occupancy < 3'd2);

  // A redirect in the response cycle kills the returning word as well.
  assign push  = inflight & (tag_epoch == epoch) & ~redirect_valid;

  assign imem_en   = issue;
  assign imem_addr = fetch_pc[IMEM_AW+1:2];

  assign Inst_code     = inst_valid ? q0_data : 32'd0;
  assign inst_pc       = inst_valid ? q0_pc : '0;
  assign inst_pc_plus4 = inst_valid ? (q0_pc + PC_WIDTH'(4)) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc     <= RESET_PC;
      tag_pc       <= '0;
      tag_epoch    <= 1'b0;
      epoch        <= 1'b0;
      inflight     <= 1'b0;
      count        <= 2'd0;
      q0_data      <= 32'd0;
      q1_data      <= 32'd0;
      q0_pc        <= '0;
      q1_pc        <= '0;
      misalign_err <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[PC_WIDTH-1:2], 2'b00};
      epoch    <= ~epoch;
      inflight <= 1'b0;
      count    <= 2'd0;
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_err <= 1'b1;
      end
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc  <= fetch_pc + PC_WIDTH'(4);
        tag_pc    <= fetch_pc;
        tag_epoch <= epoch;
      end
      // Shift the queue on pop, then write the new word into the first free
      // slot as seen after that pop.
      if (pop) begin
        q0_data <= q1_data;
        q0_pc   <= q1_pc;
      end
      if (push) begin
        if (count_after_pop == 2'd0) begin
          q0_data <= imem_rdata;
          q0_pc   <= tag_pc;
        end else begin
          q1_data <= imem_rdata;
          q1_pc   <= tag_pc;
        end
      end
      count <= count_after_pop + {1'b0, push};
    end
  end

`ifdef FETCH_HALT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt_q <= 1'b0;
    end else if (redirect_valid) begin
      halt_q <= 1'b0;
    end else if (push && (imem_rdata[31:26] == 6'b111111)) begin
      halt_q <= 1'b1;
    end
  end
`else
  assign halt_q = 1'b0;
`endif

  assign halted = halt_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_unit
// Purpose  : Self-checking bench for inst_fetch_unit. A behavioural memory
//            returns 32'h1000_0000 + word address; expected {word, pc} pairs
//            are queued when a fetch phase starts and compared on each pop.
//            A second instance with RESET_PC = FFFF_FFFC covers PC wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_unit;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_en;
  logic [5:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] Inst_code;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;
  logic        misalign_err;
  logic        halted;

  logic        imem_en_2;
  logic [5:0]  imem_addr_2;
  logic [31:0] imem_rdata_2;
  logic        inst_valid_2;
  logic [31:0] Inst_code_2;
  logic [31:0] inst_pc_2;
  logic [31:0] inst_pc_plus4_2;
  logic        misalign_err_2;
  logic        halted_2;
  logic        zero_bit = 1'b0;
  logic        one_bit  = 1'b1;
  logic [31:0] zero_pc  = 32'd0;

  logic        halt_mode = 1'b0;
  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          wrap_idx = 0;

  always #5 clk = ~clk;

  inst_fetch_unit #(.PC_WIDTH(32), .IMEM_AW(6), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .Inst_code(Inst_code), .inst_pc(inst_pc), .inst_pc_plus4(inst_pc_plus4),
    .misalign_err(misalign_err), .halted(halted)
  );

  inst_fetch_unit #(.PC_WIDTH(32), .IMEM_AW(6), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .imem_en(imem_en_2), .imem_addr(imem_addr_2),
    .imem_rdata(imem_rdata_2), .redirect_valid(zero_bit),
    .redirect_pc(zero_pc), .inst_valid(inst_valid_2), .inst_ready(one_bit),
    .Inst_code(Inst_code_2), .inst_pc(inst_pc_2), .inst_pc_plus4(inst_pc_plus4_2),
    .misalign_err(misalign_err_2), .halted(halted_2)
  );

  function automatic logic [31:0] memw(input logic [5:0] a, input logic hm);
    if (hm && a == 6'd3) return 32'hFC00_0000;
    return 32'h1000_0000 + {26'd0, a};
  endfunction

  always @(posedge clk) begin
    if (imem_en)   imem_rdata   <= memw(imem_addr, halt_mode);
    if (imem_en_2) imem_rdata_2 <= memw(imem_addr_2, 1'b0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_stream(input logic [31:0] start_pc, input int n);
    logic [31:0] pc;
    for (int i = 0; i < n; i++) begin
      pc = start_pc + 32'(4 * i);
      sb.push_back({memw(pc[7:2], halt_mode), pc});
    end
  endtask

  // Sample at the falling edge, then advance past the next rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (inst_valid && inst_ready && sb.size() > 0) begin
      e = sb.pop_front();
      chk("inst_code", Inst_code, e.data);
      chk("inst_pc", inst_pc, e.pc);
      chk("inst_pc_plus4", inst_pc_plus4, e.pc + 32'd4);
    end
    if (dut.push) chk("no_push_when_full", 32'(dut.count == 2'd2), 32'd0);
    if (inst_valid_2 && wrap_idx < 2) begin
      chk("wrap_pc", inst_pc_2, (wrap_idx == 0) ? 32'hFFFF_FFFC : 32'h0);
      chk("wrap_pc_plus4", inst_pc_plus4_2, (wrap_idx == 0) ? 32'h0 : 32'h4);
      chk("wrap_code", Inst_code_2, (wrap_idx == 0) ? 32'h1000_003F : 32'h1000_0000);
      wrap_idx++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) tick();
    chk("drain_timeout_left", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    rst = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_code", Inst_code, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_inst_pc_plus4", inst_pc_plus4, 32'd0);
    chk("rst_imem_en", 32'(imem_en), 32'd0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_wrap_pc_plus4", inst_pc_plus4_2, 32'd0);

    // Release: first issue at RESET_PC, inst_valid two cycles later
    rst = 1'b0; inst_ready = 1'b1;
    #1;
    chk("first_issue_en", 32'(imem_en), 32'd1);
    chk("first_issue_addr", 32'(imem_addr), 32'd0);
    push_stream(32'h0, 20);
    tick();
    chk("latency_valid_low", 32'(inst_valid), 32'd0);
    tick();
    chk("latency_valid_high", 32'(inst_valid), 32'd1);
    repeat (6) tick();

    // Backpressure mid-stream
    inst_ready = 1'b0;
    held = Inst_code;
    for (int k = 0; k < 5; k++) begin
      if (k >= 1) chk("bp_imem_en", 32'(imem_en), 32'd0);
      chk("bp_valid", 32'(inst_valid), 32'd1);
      chk("bp_code_stable", Inst_code, held);
      tick();
    end
    inst_ready = 1'b1;
    drain();

    // Redirect with a word in flight
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1;
    chk("redir_no_issue", 32'(imem_en), 32'd0);
    tick();
    redirect_valid = 1'b0;
    chk("redir_flush", 32'(inst_valid), 32'd0);
    push_stream(32'h40, 8);
    drain();

    // Misaligned redirect from a full queue
    inst_ready = 1'b0;
    repeat (3) tick();
    chk("pre_misalign", 32'(misalign_err), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h23;
    tick();
    redirect_valid = 1'b0;
    chk("misalign_flush", 32'(inst_valid), 32'd0);
    chk("misalign_set", 32'(misalign_err), 32'd1);
    push_stream(32'h20, 6);
    inst_ready = 1'b1;
    drain();
    chk("misalign_sticky", 32'(misalign_err), 32'd1);

    // Back-to-back redirects: last one wins
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_pc = 32'h30;
    tick();
    redirect_valid = 1'b0;
    push_stream(32'h30, 4);
    drain();

    // Reset mid-operation
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(inst_valid), 32'd0);
    chk("midrst_misalign", 32'(misalign_err), 32'd0);
    chk("midrst_imem_en", 32'(imem_en), 32'd0);
    tick();
    tick();
`ifdef FETCH_HALT_EN
    halt_mode = 1'b1;
`endif
    rst = 1'b0;
    push_stream(32'h0, `ifdef FETCH_HALT_EN 4 `else 5 `endif);
    drain();

`ifdef FETCH_HALT_EN
    tick();
    chk("halt_set", 32'(halted), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("halt_no_issue", 32'(imem_en), 32'd0);
      tick();
    end
    halt_mode = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0;
    chk("halt_cleared", 32'(halted), 32'd0);
    chk("halt_resume_issue", 32'(imem_en), 32'd1);
    push_stream(32'h0, 4);
    drain();
`else
    chk("halted_tied_low", 32'(halted), 32'd0);
`endif

    chk("wrap_seen", 32'(wrap_idx), 32'd2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
